top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 25 ++
 rtl/row_mem.sv | 27 ++
 rtl/top.sv | 163 ++++++++++++++++
 tb/tb_top.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared types and fixed-point helpers for the serial-load linear-regression trainer.
// Latency: none, declarations only.
// Backpressure: not applicable.
package top_pkg;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_PREDICT = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int FRAC_BITS = 8;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7fff;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/row_mem.sv
// Row storage: one synchronous write port, one synchronous read port.
// Latency: read data valid one clock after rd_en.
// Backpressure: none, both ports accept every cycle.
module row_mem #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 256,
    parameter int MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [MEM_AW-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    input  logic                  rd_en,
    input  logic [MEM_AW-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_dat
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_dat;
        if (rd_en)
            rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/top.sv
// Serially loads N+1 rows of Q8.8 samples, then trains a linear model by SGD for E passes.
// Latency: load (N+1)*(F+1)*16 cycles, then (2F+3) cycles per row per pass.
// Backpressure: none; S is consumed one bit per cycle during load only.
module top
    import top_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int MAX_FEATURES = 15,
    parameter int LENGTH       = 16,
    parameter int DATA_WIDTH   = 16 * (MAX_FEATURES + 1),
    parameter int DEPTH        = 1024
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S,
    input  logic [3:0]            feat,
    input  logic [7:0]            epoch,
    input  logic [ADDR_WIDTH-1:0] data_points,
    input  logic [3:0]            learn_rate,
    output logic                  done_
);

    localparam int MEM_AW = $clog2(DEPTH);

    state_t                          state;
    logic [3:0]                      cfg_feat;
    logic [7:0]                      cfg_epoch;
    logic [MEM_AW-1:0]               cfg_last;
    logic [3:0]                      cfg_lr;
    logic [MEM_AW-1:0]               row_idx;
    logic [7:0]                      pass_idx;
    logic [3:0]                      word_idx;
    logic [3:0]                      bit_idx;
    logic [DATA_WIDTH-1:0]           row_buf;
    logic [DATA_WIDTH-1:0]           row_nxt;
    logic [DATA_WIDTH-1:0]           rd_dat;
    logic [MAX_FEATURES:0][LENGTH-1:0] w;
    logic signed [31:0]              acc;
    logic signed [31:0]              acc_nxt;
    logic signed [15:0]              err;
    logic signed [15:0]              err_nxt;
    logic signed [15:0]              x_k;
    logic signed [15:0]              w_k;
    logic signed [15:0]              w_k_nxt;
    logic signed [31:0]              w_k_ext;
    logic signed [31:0]              y_ext;
    logic signed [31:0]              err_ext;
    logic signed [31:0]              prod_p;
    logic signed [31:0]              prod_u;
    logic signed [31:0]              upd;
    logic                            wr_en;

    assign done_ = (state == ST_DONE);
    assign wr_en = !RST && (state == ST_LOAD) && (bit_idx == 4'd15) && (word_idx == 4'd0);

    row_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_row_mem (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr (row_idx),
        .wr_dat  (row_nxt),
        .rd_en   (state == ST_FETCH),
        .rd_addr (row_idx),
        .rd_dat  (rd_dat)
    );

    // Word k of a row sits at bits [16k+15:16k]; word_idx doubles as the load cursor and the feature index.
    always_comb begin
        row_nxt = row_buf;
        row_nxt[{word_idx, bit_idx}] = S;
        x_k     = rd_dat[{word_idx, 4'd0} +: LENGTH];
        w_k     = w[word_idx];
        w_k_ext = {{16{w_k[15]}}, w_k};
        y_ext   = {{16{rd_dat[LENGTH-1]}}, rd_dat[LENGTH-1:0]};
        err_ext = {{16{err[15]}}, err};
        prod_p  = w_k * x_k;
        prod_u  = err * x_k;
        acc_nxt = (word_idx == 4'd0) ? w_k_ext : acc + (prod_p >>> FRAC_BITS);
        err_nxt = sat16(acc_nxt - y_ext);
        if (word_idx == 4'd0)
            upd = w_k_ext - (err_ext >>> cfg_lr);
        else
            upd = w_k_ext - (prod_u >>> (FRAC_BITS + int'(cfg_lr)));
        w_k_nxt = sat16(upd);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_LOAD;
            cfg_feat  <= feat;
            cfg_epoch <= epoch;
            cfg_last  <= (data_points > ADDR_WIDTH'(DEPTH - 1)) ? MEM_AW'(DEPTH - 1)
                                                                : data_points[MEM_AW-1:0];
            cfg_lr    <= learn_rate;
            row_idx   <= '0;
            pass_idx  <= '0;
            word_idx  <= feat;
            bit_idx   <= '0;
            w         <= '0;
            acc       <= '0;
            err       <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    row_buf <= row_nxt;
                    bit_idx <= bit_idx + 4'd1;
                    if (bit_idx == 4'd15) begin
                        if (word_idx == 4'd0) begin
                            if (row_idx == cfg_last) begin
                                row_idx  <= '0;
                                word_idx <= '0;
                                state    <= (cfg_epoch == 8'd0) ? ST_DONE : ST_FETCH;
                            end else begin
                                row_idx  <= row_idx + MEM_AW'(1);
                                word_idx <= cfg_feat;
                            end
                        end else begin
                            word_idx <= word_idx - 4'd1;
                        end
                    end
                end
                ST_FETCH: begin
                    word_idx <= '0;
                    state    <= ST_PREDICT;
                end
                ST_PREDICT: begin
                    acc <= acc_nxt;
                    if (word_idx == cfg_feat) begin
                        err      <= err_nxt;
                        word_idx <= '0;
                        state    <= ST_UPDATE;
                    end else begin
                        word_idx <= word_idx + 4'd1;
                    end
                end
                ST_UPDATE: begin
                    w[word_idx] <= w_k_nxt;
                    if (word_idx == cfg_feat) begin
                        word_idx <= '0;
                        if (row_idx != cfg_last) begin
                            row_idx <= row_idx + MEM_AW'(1);
                            state   <= ST_FETCH;
                        end else if (pass_idx != cfg_epoch - 8'd1) begin
                            row_idx  <= '0;
                            pass_idx <= pass_idx + 8'd1;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        word_idx <= word_idx + 4'd1;
                    end
                end
                ST_DONE:  state <= ST_DONE;
                default:  state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_top.sv
// Scoreboarded bench for the serial-load SGD trainer: expected weights and completion cycle come from a reference model.
module tb_top;
    import top_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        S = 1'b0;
    logic [3:0]  feat = 4'd0;
    logic [7:0]  epoch = 8'd0;
    logic [11:0] data_points = 12'd0;
    logic [3:0]  learn_rate = 4'd0;
    logic        done_;

    top dut (
        .CLK         (CLK),
        .RST         (RST),
        .S           (S),
        .feat        (feat),
        .epoch       (epoch),
        .data_points (data_points),
        .learn_rate  (learn_rate),
        .done_       (done_)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                 cyc;
        logic [15:0][15:0]  w;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] rows [0:7][0:15];
    exp_t        sb[$];

    function automatic longint msat(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [15:0] row_word(input int r, input int wd);
        if (r < 8) return rows[r][wd];
        return 16'h0000;
    endfunction

    task automatic model(input int f, input int n, input int e, input int l, output exp_t ex);
        longint wm [16];
        longint yh, er, xv;
        for (int k = 0; k < 16; k++) wm[k] = 0;
        for (int p = 0; p < e; p++) begin
            for (int r = 0; r <= n; r++) begin
                yh = wm[0];
                for (int k = 1; k <= f; k++) begin
                    xv = longint'($signed(rows[r][k]));
                    yh = yh + ((wm[k] * xv) >>> 8);
                end
                er = msat(yh - longint'($signed(rows[r][0])));
                wm[0] = msat(wm[0] - (er >>> l));
                for (int k = 1; k <= f; k++) begin
                    xv = longint'($signed(rows[r][k]));
                    wm[k] = msat(wm[k] - ((er * xv) >>> (8 + l)));
                end
            end
        end
        ex.cyc = (n + 1) * (f + 1) * 16 + e * (n + 1) * (2 * f + 3);
        for (int k = 0; k < 16; k++) ex.w[k] = wm[k][15:0];
    endtask

    // abort_after > 0: reset the run that many cycles after load instead of letting it finish.
    task automatic apply(input string name, input int f, input int dp, input int e, input int l,
                         input int abort_after);
        int   n;
        int   cyc;
        exp_t ex;
        exp_t got;
        logic [15:0] wd;
        n = (dp > 1023) ? 1023 : dp;
        if (abort_after == 0) begin
            model(f, n, e, l, ex);
            sb.push_back(ex);
        end
        @(negedge CLK);
        RST = 1'b1; feat = 4'(f); epoch = 8'(e); data_points = 12'(dp); learn_rate = 4'(l);
        @(negedge CLK);
        RST = 1'b0;
        // Changing the live config after reset must not disturb the captured copy.
        feat = ~feat; epoch = ~epoch; data_points = ~data_points; learn_rate = ~learn_rate;
        cyc = 0;
        for (int r = 0; r <= n; r++)
            for (int w_i = f; w_i >= 0; w_i--) begin
                wd = row_word(r, w_i);
                for (int b = 0; b < 16; b++) begin
                    S = wd[b];
                    @(negedge CLK);
                    cyc++;
                end
            end
        if (abort_after > 0) begin
            for (int i = 0; i < abort_after; i++) begin
                S = 1'($urandom);
                @(negedge CLK);
            end
            RST = 1'b1;
            @(negedge CLK);
            vectors++;
            if (done_ !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_ in reset: got %b want 0", name, done_);
            end
            vectors++;
            if (dut.w !== '0) begin
                miscompares++;
                $display("FAIL %s weights in reset: got %h want 0", name, dut.w);
            end
            return;
        end
        while (done_ !== 1'b1 && cyc < sb[0].cyc + 50) begin
            S = 1'($urandom);
            @(negedge CLK);
            cyc++;
        end
        got.cyc = cyc;
        got.w   = dut.w;
        ex = sb.pop_front();
        vectors++;
        if (got.cyc !== ex.cyc) begin
            miscompares++;
            $display("FAIL %s done cycle: got %0d want %0d", name, got.cyc, ex.cyc);
        end
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if (got.w[k] !== ex.w[k]) begin
                miscompares++;
                $display("FAIL %s w[%0d]: got %h want %h", name, k, got.w[k], ex.w[k]);
            end
        end
        repeat (8) begin
            S = 1'($urandom);
            @(negedge CLK);
        end
        vectors++;
        if (done_ !== 1'b1 || dut.w !== ex.w) begin
            miscompares++;
            $display("FAIL %s hold in DONE: done_=%b w=%h want done_=1 w=%h", name, done_, dut.w, ex.w);
        end
    endtask

    task automatic fill_random(input int n, input int f);
        for (int r = 0; r <= n; r++)
            for (int k = 0; k <= f; k++)
                rows[r][k] = 16'($urandom_range(0, 2047)) - 16'd1024;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++;
        if (done_ !== 1'b0) begin
            miscompares++;
            $display("FAIL reset done_: got %b want 0", done_);
        end
        vectors++;
        if (dut.state !== ST_LOAD) begin
            miscompares++;
            $display("FAIL reset state: got %0d want %0d", dut.state, ST_LOAD);
        end
        vectors++;
        if (dut.w !== '0) begin
            miscompares++;
            $display("FAIL reset weights: got %h want 0", dut.w);
        end
    endtask

    task automatic test_single_word();
        rows[0][0] = 16'h0100;
        apply("single_word", 0, 0, 1, 0, 0);
    endtask

    task automatic test_one_feature();
        rows[0][0] = 16'h0200; rows[0][1] = 16'h0100;
        apply("one_feature", 1, 0, 1, 1, 0);
    endtask

    task automatic test_load_only();
        fill_random(3, 14);
        apply("load_only", 14, 3, 0, 0, 0);
    endtask

    task automatic test_oscillate();
        rows[0][0] = 16'h0100; rows[0][1] = 16'h0100;
        apply("oscillate_e2", 1, 0, 2, 0, 0);
        apply("oscillate_e3", 1, 0, 3, 0, 0);
    endtask

    task automatic test_saturate();
        rows[0][0] = 16'h8000; rows[0][1] = 16'h7fff;
        apply("saturate_e1", 1, 0, 1, 0, 0);
        apply("saturate_e2", 1, 0, 2, 0, 0);
    endtask

    task automatic test_back_to_back();
        fill_random(5, 3);
        apply("multi_row", 3, 5, 3, 2, 0);
        fill_random(7, 15);
        apply("all_features", 15, 7, 2, 4, 0);
    endtask

    task automatic test_mid_reset();
        fill_random(2, 2);
        apply("mid_reset_abort", 2, 2, 2, 1, 12);
        apply("mid_reset_reload", 2, 2, 2, 1, 0);
    endtask

    task automatic test_clamp();
        apply("clamp", 0, 4095, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_one_feature();
        test_load_only();
        test_oscillate();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        test_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
